// File: rtl/macwl_dac_pkg.sv
// rtl/macwl_dac_pkg.sv - shared types and code-to-voltage helper for the word-line DAC bank
package macwl_dac_pkg;

  // Default code width; the bank itself is re-parameterised through its WIDTH parameter.
  localparam int DAC_WIDTH = 8;

  typedef logic [DAC_WIDTH-1:0] code_t;

  // ST_SETTLE is only reachable when the ramp logic is compiled in.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Full-scale code maps to vref, code 0 maps to 0.0 V.
  function automatic real code_to_volt(input int unsigned code, input int width, input real vref);
    return vref * real'(code) / real'((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/macwl_dac_chan.sv
// rtl/macwl_dac_chan.sv - one DAC channel: shadow/active codes, plus target and slew step under MACWL_DAC_RAMP_EN
module macwl_dac_chan
  import macwl_dac_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef MACWL_DAC_RAMP_EN
  , parameter int STEP = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit_en,
`ifdef MACWL_DAC_RAMP_EN
  input  logic             tick,
  output logic             settled,
`endif
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;

`ifdef MACWL_DAC_RAMP_EN
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH:0]   act_x, tgt_x, gap, mv, nxt;

  // Shadow write, commit merge into target, and a clamped slew step toward the target.
  always_comb begin
    shadow_d = wr_en ? wr_data : shadow_q;
    target_d = commit_en ? shadow_d : target_q;
    act_x    = {1'b0, active_q};
    tgt_x    = {1'b0, target_q};
    if (tgt_x >= act_x) begin
      gap = tgt_x - act_x;
      mv  = (gap < STEP_X) ? gap : STEP_X;
      nxt = act_x + mv;
    end else begin
      gap = act_x - tgt_x;
      mv  = (gap < STEP_X) ? gap : STEP_X;
      nxt = act_x - mv;
    end
    settled  = (nxt == tgt_x);
    active_d = tick ? nxt[WIDTH-1:0] : active_q;
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      target_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      target_q <= target_d;
      active_q <= active_d;
    end
  end
`else
  // Shadow write; commit copies the (write-merged) shadow straight to the active code.
  always_comb begin
    shadow_d = wr_en ? wr_data : shadow_q;
    active_d = commit_en ? shadow_d : active_q;
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
`endif

  assign active = active_q;

endmodule

// File: rtl/macwl_dac_bank.sv
// rtl/macwl_dac_bank.sv - word-line DAC bank top: write decode, commit FSM, optional ramp (MACWL_DAC_RAMP_EN)
module macwl_dac_bank
  import macwl_dac_pkg::*;
#(
  parameter int  NCH       = 8,
  parameter int  WIDTH     = 8,
  parameter real VREF      = 3.3,
  parameter int  RAMP_STEP = 1,
  parameter int  RAMP_DIV  = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(NCH)-1:0]   wr_chan,
  input  logic                     wr_bcast,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_err,
  input  logic                     commit,
  output logic                     busy,
  output logic                     done,
  output logic [NCH*WIDTH-1:0]     code_out,
  output real                      analog_out [NCH]
);

  localparam int             CW    = $clog2(NCH);
  localparam logic [CW:0]    NCH_X = (CW+1)'(NCH);

  if (NCH < 2 || RAMP_DIV < 1 || RAMP_STEP < 1 || RAMP_STEP > (2**WIDTH) - 1) begin : g_cfg_err
    $error("macwl_dac_bank: illegal NCH/RAMP_STEP/RAMP_DIV configuration");
  end

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_fire;
  logic             commit_en;
  logic [NCH-1:0]   chan_wr;

  // Write handshake and per-channel write enables; out-of-range unicast writes are dropped.
  always_comb begin
    wr_fire  = wr_valid && wr_ready;
    wr_err_d = wr_fire && !wr_bcast && ({1'b0, wr_chan} >= NCH_X);
    for (int i = 0; i < NCH; i++) begin
      chan_wr[i] = wr_fire && (wr_bcast || (wr_chan == CW'(i)));
    end
  end

`ifdef MACWL_DAC_RAMP_EN
  localparam int            PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [NCH-1:0] chan_settled;

  // Commit starts a ramp; in SETTLE the prescaler paces ticks and the last tick returns to IDLE.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    commit_en = 1'b0;
    tick      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          commit_en = 1'b1;
          presc_d   = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (presc_q == PRESC_LAST) begin
          tick    = 1'b1;
          presc_d = '0;
          if (&chan_settled) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) presc_q <= '0;
    else         presc_q <= presc_d;
  end
`else
  // Commit applies immediately, so the FSM never leaves IDLE.
  always_comb begin
    state_d   = ST_IDLE;
    commit_en = commit;
    done_d    = commit;
  end
`endif

  // FSM state and one-cycle status pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    macwl_dac_chan #(
      .WIDTH (WIDTH)
`ifdef MACWL_DAC_RAMP_EN
      , .STEP(RAMP_STEP)
`endif
    ) u_chan (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .wr_en     (chan_wr[g]),
      .wr_data   (wr_data),
      .commit_en (commit_en),
`ifdef MACWL_DAC_RAMP_EN
      .tick      (tick),
      .settled   (chan_settled[g]),
`endif
      .active    (code_out[g*WIDTH +: WIDTH])
    );
  end

  assign wr_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_SETTLE);
  assign done     = done_q;
  assign wr_err   = wr_err_q;

  // Behavioural voltage view of each active code.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      analog_out[i] = code_to_volt(32'(code_out[i*WIDTH +: WIDTH]), WIDTH, VREF);
    end
  end

endmodule

// File: doc/macwl_dac_bank.md
# macwl_dac_bank

Parametrised word-line DAC bank for the 1k-array MAC control path. Holds one shadow code and one active code per channel, accepts per-channel or broadcast code writes over a valid/ready port, and commits every shadow code to the active codes atomically on a single commit pulse. With the ramp feature compiled in, active codes slew toward their targets at a programmable rate, so the word lines never see a full-scale step. Sits between the array sequencer and the behavioural word-line drivers, exporting both digital codes and real-valued voltages.

## Interface
- NCH, 8, number of word-line channels (≥2)
- WIDTH, 8, DAC code width
- VREF, 3.3 (real), full-scale voltage
- RAMP_STEP, 1, maximum code change per ramp tick (1..2^WIDTH-1)
- RAMP_DIV, 1, sys_clk cycles per ramp tick (≥1)
- sys_clk  in  1  clock
- sys_rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  code write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_chan  in  $clog2(NCH)  target channel
- wr_bcast  in  1  write wr_data to all channels, ignoring wr_chan
- wr_data  in  WIDTH  code
- wr_err  out  1  one-cycle pulse: accepted non-broadcast write with wr_chan ≥ NCH
- commit  in  1  one-cycle pulse: transfer shadow to active
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse: active codes equal committed targets
- code_out  out  NCH×WIDTH  active code per channel
- analog_out  out  real[NCH]  VREF*code_out[i]/(2^WIDTH-1)

## Operation
- FSM: IDLE, SETTLE. SETTLE exists only with the ramp feature compiled in.
- wr_ready = (state == IDLE). An accepted write updates shadow[wr_chan], or every shadow when wr_bcast is high. An out-of-range address drops the data and pulses wr_err.
- A commit in IDLE latches target[i] = shadow[i]. A write accepted in the same cycle as commit is merged into the committed value.
- Commit while busy is ignored. Writes cannot occur while busy because wr_ready is low.
- Shadow registers persist across commits. Only written channels change.
- Ramp: a prescaler counts RAMP_DIV cycles per tick. On each tick, every channel moves toward its target by min(RAMP_STEP, |target−active|), up or down independently. No overshoot or wrap is permitted. Arithmetic uses WIDTH+1 bits.
- SETTLE→IDLE occurs at the tick edge where all next-active values equal their targets. done pulses in the following cycle.
- analog_out is combinational from code_out.

## Timing
- Reset (any cycle, including mid-ramp): shadow=0, target=0, active=0, prescaler=0, state=IDLE. Outputs: busy=0, done=0, wr_err=0, wr_ready=1, analog_out=0.0.
- Write latency: shadow updates at the accepting edge. wr_err is high in the cycle after that edge.
- Without the ramp feature: commit sampled at edge k sets active=shadow at edge k. done is high in cycle k+1. busy is never asserted.
- With the ramp feature: commit at edge k enters SETTLE and clears the prescaler. busy is high from cycle k+1. Ticks land at edges k+RAMP_DIV·n. Once the last tick edge e has landed, busy=0 and done=1 in cycle e+1.
- Commit with shadow==active: with the ramp feature, the FSM enters SETTLE and exits at the first tick; done follows.

## Configuration
- MACWL_DAC_RAMP_EN: when defined, the SETTLE state, prescaler and slew logic are compiled in, with behaviour as above.
- When undefined, commit is immediate, busy is tied to 0, wr_ready is tied to 1, and RAMP_STEP and RAMP_DIV are unused.

## Structure
- Package macwl_dac_pkg holds the code_t typedef (logic [WIDTH-1:0] via parameterised localparam default), the state enum, and a function that converts a code to a real voltage.
- Sub-module macwl_dac_chan contains one shadow/target/active register and its step logic, instantiated NCH times in a generate loop. The top level holds the FSM, prescaler, write decode and the all-settled reduction.

## Test plan
- Reset, then write ch3=0x80 and commit (no ramp) → code_out[3]=0x80 at the commit edge; analog_out[3]≈1.6565 V; done is pulsed once; all other channels remain 0.
- With ramp, RAMP_STEP=4, RAMP_DIV=1, ch0 0→10, commit at edge k → code_out[0] is 4, 8, 10 at edges k+1, k+2, k+3; done is pulsed in cycle k+4; busy is high for cycles k+1..k+3.
- With ramp, RAMP_DIV=3, ch1 0x20→0x1E with STEP=1 → steps occur at edges k+3 and k+6; there is no undershoot; wr_ready=0 throughout.
- Broadcast write of 0xFF together with commit in the same cycle → all channels target 0xFF; a subsequent write with wr_chan=NCH pulses wr_err and leaves the shadows unchanged.
- Assert sys_rst mid-ramp → all codes are 0 on the next edge, busy=0, and no done pulse occurs.
- Assert commit while busy → it is ignored, with no change to targets and no extra done pulse.
